// File: rtl/lamp_pkg.sv
// Shared types for the lamp-sequence transmitter: step codes, FSM states,
// and helpers that turn a packed pattern into one-hot lamp drives.
package lamp_pkg;

  localparam int NUM_BITS  = 2;
  localparam int NUM_STEPS = 3;

  typedef enum logic [NUM_BITS-1:0] {
    LAMP_OFF = 2'b00,
    LAMP1    = 2'b01,
    LAMP2    = 2'b10,
    LAMP3    = 2'b11
  } lamp_code_t;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    GAP,
    FINISH
  } tx_state_t;

  // Returns {lamp3, lamp2, lamp1}; one-hot or zero by construction.
  function automatic logic [2:0] lamp_decode(input lamp_code_t code);
    case (code)
      LAMP1:   return 3'b001;
      LAMP2:   return 3'b010;
      LAMP3:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  function automatic lamp_code_t step_code(input logic [NUM_STEPS*NUM_BITS-1:0] pat,
                                           input logic [1:0]                    idx);
    return lamp_code_t'(pat[int'(idx)*NUM_BITS +: NUM_BITS]);
  endfunction

endpackage

// File: rtl/lamp_seq_tx_step_timer.sv
// Loadable down-counter used to time how long each lamp step is held.
// It stops at zero rather than wrapping, so zero stays asserted until reloaded.
module step_timer #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (!reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && count != '0)
      count <= count - 1'b1;
  end

  assign zero = (count == '0);

endmodule

// File: rtl/lamp_seq_tx.sv
// Lamp-sequence transmitter: plays a latched 3-step lamp pattern, each step
// held for a programmable time, optionally repeated with an all-off gap.
module lamp_seq_tx
  import lamp_pkg::*;
#(
  parameter int HOLD_W = 4,
  parameter int REP_W  = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [NUM_STEPS*NUM_BITS-1:0] pattern,
  input  logic [HOLD_W-1:0]             hold,
  input  logic [REP_W-1:0]              reps,
  input  logic                          gap,
  input  logic                          abort,
  output logic                          lamp1,
  output logic                          lamp2,
  output logic                          lamp3,
  output logic                          busy,
  output logic                          done,
  output logic                          aborted
);

  tx_state_t                     state;
  logic [1:0]                    step_idx;
  logic [NUM_STEPS*NUM_BITS-1:0] pat_q;
  logic [HOLD_W-1:0]             hold_q;
  logic [REP_W-1:0]              reps_q;
  logic [REP_W-1:0]              rep_cnt;
  logic                          gap_q;
  logic [2:0]                    lamps_q;

  logic [HOLD_W-1:0] hold_eff;
  logic [HOLD_W-1:0] tmr_val;
  logic              tmr_load;
  logic              tmr_en;
  logic              tmr_zero;
  logic              last_step;
  logic              more_reps;

  assign hold_eff  = (hold == '0) ? HOLD_W'(1) : hold;
  assign last_step = (step_idx == 2'(NUM_STEPS - 1));
  assign more_reps = (rep_cnt < reps_q);

  // The timer is (re)loaded whenever a step is about to start; a reload on
  // the way to GAP or FINISH is harmless because GAP reloads again.
  assign tmr_load = (state == IDLE && start) || (state == GAP) ||
                    (state == DRIVE && tmr_zero);
  assign tmr_val  = (state == IDLE) ? hold_eff - 1'b1 : hold_q - 1'b1;
  assign tmr_en   = (state == DRIVE);

  step_timer #(.W(HOLD_W)) u_hold_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      step_idx <= '0;
      pat_q    <= '0;
      hold_q   <= '0;
      reps_q   <= '0;
      rep_cnt  <= '0;
      gap_q    <= 1'b0;
      lamps_q  <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      aborted  <= 1'b0;
    end else begin
      done    <= 1'b0;
      aborted <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            pat_q    <= pattern;
            hold_q   <= hold_eff;
            reps_q   <= reps;
            gap_q    <= gap;
            rep_cnt  <= '0;
            step_idx <= '0;
            lamps_q  <= lamp_decode(step_code(pattern, 2'd0));
            busy     <= 1'b1;
            state    <= DRIVE;
          end
        end
        DRIVE: begin
          if (abort) begin
            lamps_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
            state   <= FINISH;
          end else if (tmr_zero) begin
            if (!last_step) begin
              step_idx <= step_idx + 2'd1;
              lamps_q  <= lamp_decode(step_code(pat_q, step_idx + 2'd1));
            end else if (more_reps) begin
              rep_cnt  <= rep_cnt + 1'b1;
              step_idx <= '0;
              if (gap_q) begin
                lamps_q <= '0;
                state   <= GAP;
              end else begin
                lamps_q <= lamp_decode(step_code(pat_q, 2'd0));
              end
            end else begin
              lamps_q <= '0;
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= FINISH;
            end
          end
        end
        GAP: begin
          if (abort) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            aborted <= 1'b1;
            state   <= FINISH;
          end else begin
            lamps_q <= lamp_decode(step_code(pat_q, 2'd0));
            state   <= DRIVE;
          end
        end
        FINISH:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign lamp1 = lamps_q[0];
  assign lamp2 = lamps_q[1];
  assign lamp3 = lamps_q[2];

  a_lamps_onehot0: assert property (@(posedge clk) $onehot0({lamp3, lamp2, lamp1}));

endmodule

// File: tb/tb_lamp_seq_tx.sv
// Directed, table-driven bench for lamp_seq_tx: one record per clock edge
// holding the inputs driven before the edge and the outputs expected after it.
module tb_lamp_seq_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [5:0] pattern;
  logic [3:0] hold;
  logic [2:0] reps;
  logic       gap;
  logic       abort;
  logic       lamp1, lamp2, lamp3, busy, done, aborted;

  lamp_seq_tx #(.HOLD_W(4), .REP_W(3)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .pattern (pattern),
    .hold    (hold),
    .reps    (reps),
    .gap     (gap),
    .abort   (abort),
    .lamp1   (lamp1),
    .lamp2   (lamp2),
    .lamp3   (lamp3),
    .busy    (busy),
    .done    (done),
    .aborted (aborted)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_v;
    logic       start_v;
    logic       abort_v;
    logic [5:0] pattern_v;
    logic [3:0] hold_v;
    logic [2:0] reps_v;
    logic       gap_v;
    logic [2:0] exp_lamps;   // {lamp3, lamp2, lamp1}
    logic       exp_busy;
    logic       exp_done;
    logic       exp_aborted;
  } vec_t;

  localparam logic [2:0] OFF = 3'b000;
  localparam logic [2:0] L1  = 3'b001;
  localparam logic [2:0] L2  = 3'b010;
  localparam logic [2:0] L3  = 3'b100;
  localparam logic [5:0] PAT = 6'b11_10_01;

  vec_t       vecs[$];
  int         total = 0;
  int         bad   = 0;
  logic [5:0] c_pat;
  logic [3:0] c_hold;
  logic [2:0] c_reps;
  logic       c_gap;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic cfg(input logic [5:0] p, input logic [3:0] h, input logic [2:0] r, input logic g);
    c_pat = p; c_hold = h; c_reps = r; c_gap = g;
  endtask

  task automatic v(input logic s, input logic a, input logic [2:0] el,
                   input logic eb, input logic ed, input logic ea);
    vec_t t;
    t = '{1'b1, s, a, c_pat, c_hold, c_reps, c_gap, el, eb, ed, ea};
    vecs.push_back(t);
  endtask

  task automatic vr(input int n, input logic [2:0] el);
    for (int i = 0; i < n; i++) v(1'b0, 1'b0, el, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic vrst();
    vec_t t;
    t = '{1'b0, 1'b0, 1'b0, c_pat, c_hold, c_reps, c_gap, OFF, 1'b0, 1'b0, 1'b0};
    vecs.push_back(t);
  endtask

  task automatic vidle(input int n);
    for (int i = 0; i < n; i++) v(1'b0, 1'b0, OFF, 1'b0, 1'b0, 1'b0);
  endtask

  int   busy_cycles;
  logic seen_done;

  initial begin
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    pattern = '0; hold = '0; reps = '0; gap = 1'b0;

    // Reset held two cycles, then quiet idle.
    cfg(PAT, 4'd1, 3'd0, 1'b0);
    vrst(); vrst();
    vidle(10);

    // Single pass, hold=1: lamp1, lamp2, lamp3 back to back.
    cfg(PAT, 4'd1, 3'd0, 1'b0);
    v(1, 0, L1, 1, 0, 0); vr(1, L2); vr(1, L3);
    v(0, 0, OFF, 0, 1, 0); vidle(1);

    // hold=3, one repeat with gap; pattern/gap scrambled after start,
    // extra starts mid-run and during FINISH must be ignored.
    cfg(PAT, 4'd3, 3'd1, 1'b1);
    v(1, 0, L1, 1, 0, 0);
    cfg(6'b00_00_00, 4'd0, 3'd0, 1'b0);
    vr(1, L1); v(1, 0, L1, 1, 0, 0); v(1, 0, L2, 1, 0, 0); vr(2, L2); vr(3, L3);
    v(0, 0, OFF, 1, 0, 0);
    vr(3, L1); vr(3, L2); vr(3, L3);
    v(0, 0, OFF, 0, 1, 0);
    v(1, 0, OFF, 0, 0, 0); vidle(1);

    // Abort in DRIVE, abort ignored in FINISH/IDLE, start beats abort.
    cfg(PAT, 4'd3, 3'd0, 1'b0);
    v(1, 0, L1, 1, 0, 0); vr(1, L1);
    v(0, 1, OFF, 0, 1, 1);
    v(0, 1, OFF, 0, 0, 0);
    v(0, 1, OFF, 0, 0, 0);
    v(1, 1, L1, 1, 0, 0); vr(2, L1); vr(3, L2); vr(3, L3);
    v(0, 0, OFF, 0, 1, 0); vidle(1);

    // Abort during the GAP cycle.
    cfg(PAT, 4'd1, 3'd1, 1'b1);
    v(1, 0, L1, 1, 0, 0); vr(1, L2); vr(1, L3);
    v(0, 0, OFF, 1, 0, 0);
    v(0, 1, OFF, 0, 1, 1); vidle(1);

    // Reset mid-DRIVE: everything drops, no done pulse follows.
    cfg(PAT, 4'd3, 3'd0, 1'b0);
    v(1, 0, L1, 1, 0, 0); vr(1, L1);
    vrst(); vidle(3);

    // hold=0 behaves exactly like hold=1.
    cfg(PAT, 4'd0, 3'd0, 1'b0);
    v(1, 0, L1, 1, 0, 0); vr(1, L2); vr(1, L3);
    v(0, 0, OFF, 0, 1, 0); vidle(1);

    // Code 00 step keeps lamps dark while still busy.
    cfg(6'b00_11_10, 4'd0, 3'd0, 1'b0);
    v(1, 0, L2, 1, 0, 0); vr(1, L3); vr(1, OFF);
    v(0, 0, OFF, 0, 1, 0); vidle(1);

    // Two repeats without gap: passes run back to back.
    cfg(PAT, 4'd1, 3'd2, 1'b0);
    v(1, 0, L1, 1, 0, 0); vr(1, L2); vr(1, L3);
    vr(1, L1); vr(1, L2); vr(1, L3);
    vr(1, L1); vr(1, L2); vr(1, L3);
    v(0, 0, OFF, 0, 1, 0); vidle(1);

    foreach (vecs[i]) begin
      @(negedge clk);
      reset   = vecs[i].rst_v;
      start   = vecs[i].start_v;
      abort   = vecs[i].abort_v;
      pattern = vecs[i].pattern_v;
      hold    = vecs[i].hold_v;
      reps    = vecs[i].reps_v;
      gap     = vecs[i].gap_v;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i),
            {26'd0, lamp3, lamp2, lamp1, busy, done, aborted},
            {26'd0, vecs[i].exp_lamps, vecs[i].exp_busy, vecs[i].exp_done, vecs[i].exp_aborted});
    end

    // Longest run: hold=15, reps=7 (max), gap on -> 8*45 + 7 = 367 busy cycles.
    @(negedge clk);
    reset = 1'b1; start = 1'b1; abort = 1'b0;
    pattern = PAT; hold = 4'd15; reps = 3'd7; gap = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    busy_cycles = 0;
    seen_done   = 1'b0;
    for (int i = 0; i < 1000 && !seen_done; i++) begin
      if (done) begin
        seen_done = 1'b1;
      end else begin
        if (busy) busy_cycles++;
        @(posedge clk);
        #1;
      end
    end
    check("long_done_seen", {31'd0, seen_done}, 32'd1);
    check("long_busy_cycles", busy_cycles, 32'd367);
    check("long_not_aborted", {31'd0, aborted}, 32'd0);
    @(posedge clk);
    #1;
    check("long_idle_after", {29'd0, busy, done, aborted}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
